// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types and helpers for key_expander.
// Optional round-key cache is enabled by defining KEY_EXPANDER_CACHE_EN.
package aes_pkg;

  localparam int NUM_ROUNDS_AES128 = 10;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] key_t;

  // Round constant for rounds 1..10; any other index yields 0.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_expander_if.sv
// Handshake/bus bundle between the cipher datapath (master) and key_expander (slave).
// Cache read ports exist only when KEY_EXPANDER_CACHE_EN is defined.
interface key_expander_if;
  import aes_pkg::*;

  logic        key_load;
  key_t        cipher_key;
  logic        round_adv;
  logic [3:0]  round_count;
  key_t        round_key;
  logic [3:0]  key_round;
  logic        key_valid;
  logic        key_done;
  logic        sync_err;
`ifdef KEY_EXPANDER_CACHE_EN
  logic [3:0]  rd_round;
  key_t        rd_key;
  logic        cache_full;
`endif

  modport master (
    output key_load, cipher_key, round_adv, round_count,
`ifdef KEY_EXPANDER_CACHE_EN
    output rd_round,
    input  rd_key, cache_full,
`endif
    input  round_key, key_round, key_valid, key_done, sync_err
  );

  modport slave (
    input  key_load, cipher_key, round_adv, round_count,
`ifdef KEY_EXPANDER_CACHE_EN
    input  rd_round,
    output rd_key, cache_full,
`endif
    output round_key, key_round, key_valid, key_done, sync_err
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box computed as GF(2^8) inverse followed by the affine map,
// avoiding a 256-entry table.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] m;
    p = 8'h00;
    m = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ m;
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  logic [7:0] b;

  assign b = gf_inv(a);
  assign s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;

endmodule

// File: rtl/key_expander.sv
// AES-128 on-the-fly key schedule tracking round_counter; flags loss of lock.
// Defining KEY_EXPANDER_CACHE_EN adds a per-round key cache with a combinational read port.
module key_expander
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_AES128
) (
  input logic         clk,
  input logic         n_rst,
  key_expander_if.slave bus
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t     state;
  key_t       key_q;
  logic [3:0] round_q;
  logic       valid_q;
  logic       done_q;
  logic       err_q;

  word_t      w0, w1, w2, w3;
  word_t      rot, sub, t;
  word_t      n0, n1, n2, n3;
  key_t       key_next;
  logic [3:0] round_next;
  logic       adv_ok;

  assign {w0, w1, w2, w3} = key_q;
  assign rot = rot_word(w3);

  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox u_sbox (.a(rot[8*i +: 8]), .s(sub[8*i +: 8]));
  end

  assign round_next = round_q + 4'd1;
  assign t          = sub ^ {rcon(round_next), 24'h000000};
  assign n0         = w0 ^ t;
  assign n1         = w1 ^ n0;
  assign n2         = w2 ^ n1;
  assign n3         = w3 ^ n2;
  assign key_next   = {n0, n1, n2, n3};
  assign adv_ok     = bus.round_adv & (state == EXPAND) & ~bus.key_load;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (bus.key_load) begin
      state   <= EXPAND;
      key_q   <= bus.cipher_key;
      round_q <= '0;
      valid_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        EXPAND: begin
          if (bus.round_adv) begin
            key_q   <= key_next;
            round_q <= round_next;
            if (bus.round_count != round_q) err_q <= 1'b1;
            if (round_next == LAST) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.round_key = key_q;
  assign bus.key_round = round_q;
  assign bus.key_valid = valid_q;
  assign bus.key_done  = done_q;
  assign bus.sync_err  = err_q;

`ifdef KEY_EXPANDER_CACHE_EN
  key_t cache [0:NUM_ROUNDS];

  // Entries are deliberately not reset or cleared on load; only cache_full tracks freshness.
  always_ff @(posedge clk) begin
    if (bus.key_load)  cache[0]          <= bus.cipher_key;
    else if (adv_ok)   cache[round_next] <= key_next;
  end

  assign bus.rd_key     = (bus.rd_round <= LAST) ? cache[bus.rd_round] : '0;
  assign bus.cache_full = done_q;
`else
  logic unused_adv;
  assign unused_adv = adv_ok;
`endif

endmodule

// File: tb/tb_key_expander.sv
// Self-checking bench for key_expander against a table-driven AES key-schedule model.
// Cache checks run only when KEY_EXPANDER_CACHE_EN is defined.
module tb_key_expander;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  key_expander_if bus();
  key_expander dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  byte unsigned sb [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  byte unsigned rc [11] = '{8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic [127:0] m_key;
  int           m_round;
  bit           m_valid, m_done, m_err;

  // Reference key schedule: produces the round-r key from the round-(r-1) key.
  function automatic logic [127:0] model_expand(input logic [127:0] k, input int r);
    logic [31:0] w [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    t = {sb[w[3][23:16]] ^ rc[r], sb[w[3][15:8]], sb[w[3][7:0]], sb[w[3][31:24]]};
    w[0] = w[0] ^ t;
    for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic model_reset();
    m_key = '0; m_round = 0; m_valid = 0; m_done = 0; m_err = 0;
  endtask

  // One clock of stimulus; the model follows the same edge.
  task automatic cycle(input bit load, input logic [127:0] key, input bit adv, input int cnt);
    bus.key_load    = load;
    bus.cipher_key  = key;
    bus.round_adv   = adv;
    bus.round_count = 4'(cnt);
    @(posedge clk);
    #1;
    bus.key_load  = 1'b0;
    bus.round_adv = 1'b0;
    if (load) begin
      m_key = key; m_round = 0; m_valid = 1; m_done = 0; m_err = 0;
    end else if (adv && m_valid && !m_done) begin
      if (cnt != m_round) m_err = 1;
      m_round = m_round + 1;
      m_key   = model_expand(m_key, m_round);
      m_done  = (m_round == 10);
    end
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    n_rst = 1'b0;
    model_reset();
    #3;
    n_checks++;
    if ({bus.round_key, bus.key_round, bus.key_valid, bus.key_done, bus.sync_err} !== 135'h0) begin
      n_fail++;
      $display("FAIL reset_state got key=%h rnd=%0d v=%b d=%b e=%b want all 0",
               bus.round_key, bus.key_round, bus.key_valid, bus.key_done, bus.sync_err);
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(0, rand_key(), 1, $urandom_range(0, 15));
      n_checks++;
      if ({bus.round_key, bus.key_round, bus.key_valid, bus.key_done, bus.sync_err} !== 135'h0) begin
        n_fail++;
        $display("FAIL idle_adv[%0d] got key=%h rnd=%0d v=%b d=%b e=%b want all 0", i,
                 bus.round_key, bus.key_round, bus.key_valid, bus.key_done, bus.sync_err);
      end
    end
  endtask

  task automatic test_known_vector();
    cycle(1, FIPS_KEY, 0, 0);
    n_checks++;
    if ({bus.round_key, bus.key_round, bus.key_valid, bus.key_done} !== {FIPS_KEY, 4'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL fips_load got key=%h rnd=%0d v=%b d=%b want key=%h rnd=0 v=1 d=0",
               bus.round_key, bus.key_round, bus.key_valid, bus.key_done, FIPS_KEY);
    end
    cycle(0, '0, 1, 0);
    n_checks++;
    if ({bus.round_key, bus.key_round} !== {FIPS_R1, 4'd1}) begin
      n_fail++;
      $display("FAIL fips_round1 got key=%h rnd=%0d want key=%h rnd=1",
               bus.round_key, bus.key_round, FIPS_R1);
    end
    for (int r = 1; r < 10; r++) begin
      cycle(0, '0, 1, r);
      n_checks++;
      if ({bus.round_key, bus.key_round, bus.key_valid, bus.key_done, bus.sync_err} !==
          {m_key, 4'(m_round), m_valid, m_done, m_err}) begin
        n_fail++;
        $display("FAIL fips_round%0d got key=%h rnd=%0d d=%b e=%b want key=%h rnd=%0d d=%b e=%b",
                 r + 1, bus.round_key, bus.key_round, bus.key_done, bus.sync_err,
                 m_key, m_round, m_done, m_err);
      end
    end
    n_checks++;
    if ({bus.round_key, bus.key_round, bus.key_done, bus.sync_err} !== {FIPS_R10, 4'd10, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL fips_round10 got key=%h rnd=%0d d=%b e=%b want key=%h rnd=10 d=1 e=0",
               bus.round_key, bus.key_round, bus.key_done, bus.sync_err, FIPS_R10);
    end
    cycle(0, '0, 1, 3);
    n_checks++;
    if ({bus.round_key, bus.key_round, bus.key_valid, bus.key_done, bus.sync_err} !==
        {FIPS_R10, 4'd10, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL done_hold got key=%h rnd=%0d v=%b d=%b e=%b want key=%h rnd=10 v=1 d=1 e=0",
               bus.round_key, bus.key_round, bus.key_valid, bus.key_done, bus.sync_err, FIPS_R10);
    end
  endtask

`ifdef KEY_EXPANDER_CACHE_EN
  task automatic test_cache();
    logic [127:0] exp_tab [4];
    int           rd_tab  [4];
    rd_tab = '{1, 12, 10, 0};
    exp_tab = '{FIPS_R1, 128'h0, FIPS_R10, FIPS_KEY};
    for (int i = 0; i < 4; i++) begin
      bus.rd_round = 4'(rd_tab[i]);
      #1;
      n_checks++;
      if (bus.rd_key !== exp_tab[i] || bus.cache_full !== 1'b1) begin
        n_fail++;
        $display("FAIL cache_rd%0d got key=%h full=%b want key=%h full=1",
                 rd_tab[i], bus.rd_key, bus.cache_full, exp_tab[i]);
      end
    end
    cycle(1, rand_key(), 0, 0);
    bus.rd_round = 4'd10;
    #1;
    n_checks++;
    if (bus.rd_key !== FIPS_R10 || bus.cache_full !== 1'b0) begin
      n_fail++;
      $display("FAIL cache_after_load got key=%h full=%b want key=%h full=0",
               bus.rd_key, bus.cache_full, FIPS_R10);
    end
    bus.rd_round = 4'd0;
    #1;
    n_checks++;
    if (bus.rd_key !== m_key) begin
      n_fail++;
      $display("FAIL cache_entry0 got %h want %h", bus.rd_key, m_key);
    end
  endtask
`endif

  task automatic test_sync_err();
    cycle(1, rand_key(), 0, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 1);
    cycle(0, '0, 1, 5);
    n_checks++;
    if ({bus.sync_err, bus.key_round, bus.round_key} !== {1'b1, 4'd3, m_key}) begin
      n_fail++;
      $display("FAIL sync_set got e=%b rnd=%0d key=%h want e=1 rnd=3 key=%h",
               bus.sync_err, bus.key_round, bus.round_key, m_key);
    end
    for (int r = 3; r < 6; r++) begin
      cycle(0, '0, 1, r);
      n_checks++;
      if ({bus.sync_err, bus.key_round} !== {1'b1, 4'(m_round)}) begin
        n_fail++;
        $display("FAIL sync_sticky got e=%b rnd=%0d want e=1 rnd=%0d",
                 bus.sync_err, bus.key_round, m_round);
      end
    end
    cycle(1, rand_key(), 0, 0);
    n_checks++;
    if ({bus.sync_err, bus.key_round, bus.round_key} !== {1'b0, 4'd0, m_key}) begin
      n_fail++;
      $display("FAIL sync_clear got e=%b rnd=%0d want e=0 rnd=0", bus.sync_err, bus.key_round);
    end
  endtask

  task automatic test_load_priority();
    logic [127:0] k2;
    cycle(1, rand_key(), 0, 0);
    for (int r = 0; r < 4; r++) cycle(0, '0, 1, r);
    k2 = rand_key();
    cycle(1, k2, 1, 4);
    n_checks++;
    if ({bus.round_key, bus.key_round, bus.key_valid, bus.key_done, bus.sync_err} !==
        {k2, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL load_priority got key=%h rnd=%0d v=%b want key=%h rnd=0 v=1",
               bus.round_key, bus.key_round, bus.key_valid, k2);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, rand_key(), 0, 0);
    for (int r = 0; r < 3; r++) cycle(0, '0, 1, r);
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({bus.round_key, bus.key_round, bus.key_valid, bus.key_done, bus.sync_err} !== 135'h0) begin
      n_fail++;
      $display("FAIL reset_mid got key=%h rnd=%0d v=%b want all 0",
               bus.round_key, bus.key_round, bus.key_valid);
    end
    @(negedge clk);
    n_rst = 1'b1;
    cycle(0, '0, 1, 0);
    n_checks++;
    if ({bus.key_round, bus.key_valid} !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_mid_adv got rnd=%0d v=%b want rnd=0 v=0", bus.key_round, bus.key_valid);
    end
  endtask

  task automatic test_random();
    bit load, adv;
    int cnt;
    for (int i = 0; i < 400; i++) begin
      load = !m_valid || ($urandom_range(0, 24) == 0);
      adv  = ($urandom_range(0, 3) != 0);
      cnt  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : m_round;
      cycle(load, rand_key(), adv, cnt);
      n_checks++;
      if ({bus.round_key, bus.key_round, bus.key_valid, bus.key_done, bus.sync_err} !==
          {m_key, 4'(m_round), m_valid, m_done, m_err}) begin
        n_fail++;
        $display("FAIL random[%0d] got key=%h rnd=%0d v=%b d=%b e=%b want key=%h rnd=%0d v=%b d=%b e=%b",
                 i, bus.round_key, bus.key_round, bus.key_valid, bus.key_done, bus.sync_err,
                 m_key, m_round, m_valid, m_done, m_err);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_load    = 1'b0;
    bus.cipher_key  = '0;
    bus.round_adv   = 1'b0;
    bus.round_count = 4'd0;
`ifdef KEY_EXPANDER_CACHE_EN
    bus.rd_round    = 4'd0;
`endif
    test_reset();
    test_known_vector();
`ifdef KEY_EXPANDER_CACHE_EN
    test_cache();
`endif
    test_sync_err();
    test_load_priority();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
